display_framebuffer: RTL and testbench
======================================

DISPLAY_FRAMEBUFFER -- requirements
Module: display_framebuffer

Interface
REQ-001 SHALL provide parameter DEPTH, default 9600, meaning words per buffer (one pixel-word per 32-bit location).
REQ-002 SHALL provide parameter AW, default 14, meaning word-index width; DEPTH <= 2**AW.
REQ-003 SHALL provide port clk  input  1  single system clock; all state updates on its rising edge.
REQ-004 SHALL provide port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL provide port wr_en  input  1  CPU write strobe, one write per cycle.
REQ-006 SHALL provide port wr_size  input  2  00 byte, 01 half-word, 10 word, 11 reserved.
REQ-007 SHALL provide port wr_addr  input  32  byte address; bits [AW+1:2] word index, [1:0] lane.
REQ-008 SHALL provide port wr_data  input  32  write data, right-justified for byte/half.
REQ-009 SHALL provide port rd_en  input  1  display read strobe.
REQ-010 SHALL provide port rd_addr  input  32  word address; bits [AW-1:0] used.
REQ-011 SHALL provide port rd_data  output  32  registered read data from front buffer.
REQ-012 SHALL provide port rd_valid  output  1  rd_data valid this cycle.
REQ-013 SHALL provide port frame_start  input  1  one-cycle vsync pulse from display timing.
REQ-014 SHALL provide port swap_req  input  1  request front/back exchange at next frame_start.
REQ-015 SHALL provide ports swap_pending, front_sel, clr_busy, wr_err  output  1 each  swap armed; buffer being displayed; fill in progress; one-cycle dropped-write pulse.
REQ-016 SHALL provide ports clr_start  input  1  and clr_value  input  32  start back-buffer fill; fill word.

Function
REQ-017 SHALL hold two banks of DEPTH x 32 bits; reads address bank front_sel, all writes and fills address bank ~front_sel.
REQ-018 SHALL map lanes big-endian: offset 00 -> [31:24], 01 -> [23:16], 10 -> [15:8], 11 -> [7:0]; half offset 0x -> [31:16], 1x -> [15:0]; unwritten lanes keep contents.
REQ-019 SHALL drop a write and pulse wr_err the next cycle when word index >= DEPTH, half with wr_addr[0]=1, word with wr_addr[1:0]!=0, wr_size=11, or clr_busy=1.
REQ-020 SHALL return rd_data one cycle after rd_en; rd_valid = rd_en delayed one cycle; index >= DEPTH returns 0; rd_data holds when rd_en=0.
REQ-021 SHALL set swap_pending on swap_req; on frame_start with swap_pending (or swap_req same cycle) and clr_busy=0, SHALL toggle front_sel and clear swap_pending at that edge.
REQ-022 SHALL keep swap_pending set across frame_start while clr_busy=1; swap occurs at first frame_start after fill completes.
REQ-023 SHALL implement fill FSM IDLE -> FILL on clr_start in IDLE; FILL writes clr_value (captured at start) to back-buffer index 0..DEPTH-1, one word per cycle; after index DEPTH-1 returns to IDLE.
REQ-024 SHALL assert clr_busy from the cycle after clr_start for exactly DEPTH cycles; clr_start during FILL ignored.
REQ-025 SHALL allow reads of the front buffer at full rate during FILL.

Reset
REQ-026 SHALL on rst_n=0 immediately force rd_data=0, rd_valid=0, front_sel=0, swap_pending=0, clr_busy=0, wr_err=0, FSM=IDLE, fill counter=0; memory contents not reset.
REQ-027 SHALL abort an in-progress fill on reset; partially filled words remain.

Verification
REQ-028 Word write 0xDEADBEEF to 0x10, swap_req, frame_start, rd_en rd_addr=4 -> rd_data=0xDEADBEEF one cycle later, front_sel=1.
REQ-029 Byte writes 0x11,0x22,0x33,0x44 to 0x20..0x23, swap, read index 8 -> 0x11223344; half 0xABCD to 0x22 then -> 0x1122ABCD.
REQ-030 Word write to 0x02, half to 0x01, write to index 9600 -> each dropped, wr_err pulses, memory unchanged.
REQ-031 DEPTH=16: clr_start, clr_value=0xFFFF0000 -> clr_busy 16 cycles; frame_start with swap_pending mid-fill -> no swap; next frame_start -> swap; all 16 reads = 0xFFFF0000.
REQ-032 swap_req and frame_start same cycle -> front_sel toggles that edge, swap_pending stays 0.
REQ-033 rst_n low at fill index 5 -> clr_busy=0 immediately, front_sel=0, subsequent writes accepted.

Source files
------------

// File: rtl/display_framebuffer.sv
// ----------------------------------------------------------------------------
// display_framebuffer
//
// Double-buffered 32-bit pixel store. The display side reads the front bank
// and the CPU side writes (bytes, half-words or words) into the back bank. A
// fill engine can flood the back bank with one word value. A swap request is
// armed by swap_req and takes effect on the next vsync (frame_start). The
// swap is held off while a fill is running.
//
// Ports
//   clk, rst_n          system clock, asynchronous active-low reset
//   wr_en/size/addr/data CPU write into back bank (byte address, big-endian lanes)
//   rd_en, rd_addr      display read of front bank (word address)
//   rd_data, rd_valid   registered read result, valid one cycle after rd_en
//   frame_start         one-cycle vsync pulse
//   swap_req            arm a front/back exchange
//   swap_pending        exchange armed, waiting for frame_start
//   front_sel           bank currently displayed
//   clr_start/clr_value start a back-bank fill with clr_value
//   clr_busy            fill in progress (CPU writes are dropped)
//   wr_err              one-cycle pulse after a dropped CPU write
// ----------------------------------------------------------------------------
module display_framebuffer #(
  parameter int DEPTH = 9600,
  parameter int AW    = 14
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wr_en,
  input  logic [1:0]  wr_size,
  input  logic [31:0] wr_addr,
  input  logic [31:0] wr_data,
  input  logic        rd_en,
  input  logic [31:0] rd_addr,
  output logic [31:0] rd_data,
  output logic        rd_valid,
  input  logic        frame_start,
  input  logic        swap_req,
  output logic        swap_pending,
  output logic        front_sel,
  output logic        clr_busy,
  output logic        wr_err,
  input  logic        clr_start,
  input  logic [31:0] clr_value
);

  // Index width actually needed to address DEPTH words.
  localparam int          IW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);
  localparam logic [AW:0] LAST_W  = (AW+1)'(DEPTH - 1);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_FILL = 1'b1
  } fill_state_t;

  fill_state_t   r_state, w_state_next;
  logic [AW-1:0] r_fill_idx, w_fill_idx_next;
  logic [31:0]   r_clr_value;
  logic          r_front_sel;
  logic          r_swap_pending;
  logic          r_wr_err;
  logic [31:0]   r_rd_data;
  logic          r_rd_valid;

  logic [31:0]   r_mem0 [DEPTH];
  logic [31:0]   r_mem1 [DEPTH];

  // --------------------------------------------------------------------------
  // CPU write decode: lane enables (lane 3 = bits 31:24 = byte offset 0)
  // --------------------------------------------------------------------------
  logic [AW-1:0] w_wr_idx;
  logic [1:0]    w_wr_lane;
  logic          w_wr_bad;
  logic [3:0]    w_wr_be;
  logic [31:0]   w_wr_lanes;

  assign w_wr_idx  = wr_addr[AW+1:2];
  assign w_wr_lane = wr_addr[1:0];
  assign clr_busy  = (r_state == S_FILL);

  always_comb begin
    // NOTE: every output of a combinational block gets a default before any
    // branch, so no path leaves it unassigned and no latch is inferred.
    w_wr_be    = 4'b0000;
    w_wr_lanes = wr_data;
    w_wr_bad   = 1'b0;
    case (wr_size)
      2'b00: begin
        w_wr_be    = 4'b1000 >> w_wr_lane;
        w_wr_lanes = {4{wr_data[7:0]}};
      end
      2'b01: begin
        w_wr_bad   = w_wr_lane[0];
        w_wr_be    = w_wr_lane[1] ? 4'b0011 : 4'b1100;
        w_wr_lanes = {2{wr_data[15:0]}};
      end
      2'b10: begin
        w_wr_bad = (w_wr_lane != 2'b00);
        w_wr_be  = 4'b1111;
      end
      default: w_wr_bad = 1'b1;
    endcase
    if (({1'b0, w_wr_idx} >= DEPTH_W) || clr_busy) begin
      w_wr_bad = 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // Back-bank write port: the fill engine owns it while busy (CPU writes are
  // rejected then, so there is never a collision).
  // --------------------------------------------------------------------------
  logic          w_mem_we;
  logic [AW-1:0] w_mem_idx;
  logic [3:0]    w_mem_be;
  logic [31:0]   w_mem_wdata;

  always_comb begin
    w_mem_we    = 1'b0;
    w_mem_idx   = w_wr_idx;
    w_mem_be    = w_wr_be;
    w_mem_wdata = w_wr_lanes;
    if (r_state == S_FILL) begin
      w_mem_we    = 1'b1;
      w_mem_idx   = r_fill_idx;
      w_mem_be    = 4'b1111;
      w_mem_wdata = r_clr_value;
    end else if (wr_en && !w_wr_bad) begin
      w_mem_we = 1'b1;
    end
  end

  // The back bank is the one not selected by front_sel.
  always_ff @(posedge clk) begin
    // NOTE: storage arrays are deliberately not reset; clearing them is the
    // fill engine's job, and a reset term would prevent RAM inference.
    if (w_mem_we) begin
      if (r_front_sel) begin
        if (w_mem_be[3]) r_mem0[w_mem_idx[IW-1:0]][31:24] <= w_mem_wdata[31:24];
        if (w_mem_be[2]) r_mem0[w_mem_idx[IW-1:0]][23:16] <= w_mem_wdata[23:16];
        if (w_mem_be[1]) r_mem0[w_mem_idx[IW-1:0]][15:8]  <= w_mem_wdata[15:8];
        if (w_mem_be[0]) r_mem0[w_mem_idx[IW-1:0]][7:0]   <= w_mem_wdata[7:0];
      end else begin
        if (w_mem_be[3]) r_mem1[w_mem_idx[IW-1:0]][31:24] <= w_mem_wdata[31:24];
        if (w_mem_be[2]) r_mem1[w_mem_idx[IW-1:0]][23:16] <= w_mem_wdata[23:16];
        if (w_mem_be[1]) r_mem1[w_mem_idx[IW-1:0]][15:8]  <= w_mem_wdata[15:8];
        if (w_mem_be[0]) r_mem1[w_mem_idx[IW-1:0]][7:0]   <= w_mem_wdata[7:0];
      end
    end
  end

  // --------------------------------------------------------------------------
  // Front-bank read port
  // --------------------------------------------------------------------------
  logic [AW-1:0] w_rd_idx;
  logic          w_rd_in;
  logic [31:0]   w_rd_word;

  assign w_rd_idx  = rd_addr[AW-1:0];
  assign w_rd_in   = ({1'b0, w_rd_idx} < DEPTH_W);
  assign w_rd_word = r_front_sel ? r_mem1[w_rd_idx[IW-1:0]] : r_mem0[w_rd_idx[IW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: sequential state always uses non-blocking assignments so every
      // register samples pre-edge values regardless of block ordering.
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      r_rd_valid <= rd_en;
      if (rd_en) begin
        r_rd_data <= w_rd_in ? w_rd_word : '0;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Fill FSM next-state
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_next    = r_state;
    w_fill_idx_next = r_fill_idx;
    case (r_state)
      S_IDLE: begin
        if (clr_start) begin
          w_state_next    = S_FILL;
          w_fill_idx_next = '0;
        end
      end
      S_FILL: begin
        if ({1'b0, r_fill_idx} == LAST_W) begin
          w_state_next    = S_IDLE;
          w_fill_idx_next = '0;
        end else begin
          w_fill_idx_next = r_fill_idx + AW'(1);
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // A swap_req arriving together with frame_start is honoured at once.
  logic w_swap_now;
  assign w_swap_now = frame_start && (r_swap_pending || swap_req) && !clr_busy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= S_IDLE;
      r_fill_idx     <= '0;
      r_clr_value    <= '0;
      r_front_sel    <= 1'b0;
      r_swap_pending <= 1'b0;
      r_wr_err       <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_fill_idx <= w_fill_idx_next;
      if ((r_state == S_IDLE) && clr_start) begin
        r_clr_value <= clr_value;
      end
      r_wr_err <= wr_en && w_wr_bad;
      if (w_swap_now) begin
        r_front_sel    <= ~r_front_sel;
        r_swap_pending <= 1'b0;
      end else if (swap_req) begin
        r_swap_pending <= 1'b1;
      end
    end
  end

  assign rd_data      = r_rd_data;
  assign rd_valid     = r_rd_valid;
  assign front_sel    = r_front_sel;
  assign swap_pending = r_swap_pending;
  assign wr_err       = r_wr_err;

  // Address bits above the used index, and index bits above IW when DEPTH is
  // smaller than 2**AW, are intentionally ignored.
  logic w_unused;
  assign w_unused = &{1'b0, wr_addr[31:AW+2], rd_addr[31:AW], w_mem_idx, w_rd_idx};

endmodule

// File: tb/tb_display_framebuffer.sv
// ----------------------------------------------------------------------------
// tb_display_framebuffer
//
// Directed bench for display_framebuffer (DEPTH=16). A reference model keeps
// two banks as plain arrays, applies writes as mask/shift arithmetic, tracks
// the fill as a count of words left and the swap as a flag. A negedge process
// compares every DUT output against the model; directed steps also check
// hand-computed literal values.
// ----------------------------------------------------------------------------
module tb_display_framebuffer;

  localparam int DEPTH = 16;
  localparam int AW    = 14;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wr_en = 1'b0;
  logic [1:0]  wr_size = 2'b10;
  logic [31:0] wr_addr = '0;
  logic [31:0] wr_data = '0;
  logic        rd_en = 1'b0;
  logic [31:0] rd_addr = '0;
  logic [31:0] rd_data;
  logic        rd_valid;
  logic        frame_start = 1'b0;
  logic        swap_req = 1'b0;
  logic        swap_pending;
  logic        front_sel;
  logic        clr_busy;
  logic        wr_err;
  logic        clr_start = 1'b0;
  logic [31:0] clr_value = '0;

  int n_vec  = 0;
  int n_miss = 0;

  display_framebuffer #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .wr_en(wr_en), .wr_size(wr_size), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
    .frame_start(frame_start), .swap_req(swap_req),
    .swap_pending(swap_pending), .front_sel(front_sel),
    .clr_busy(clr_busy), .wr_err(wr_err),
    .clr_start(clr_start), .clr_value(clr_value)
  );

  initial forever #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // --------------------------------------------------------------------------
  // Reference model
  // --------------------------------------------------------------------------
  logic [31:0] m_mem   [2][DEPTH];
  bit          m_known [2][DEPTH];
  int          m_front     = 0;
  bit          m_pending   = 0;
  int          m_fill_left = 0;
  logic [31:0] m_fill_val  = '0;
  logic [31:0] m_rd_data   = '0;
  bit          m_rd_valid  = 0;
  bit          m_rd_known  = 1;
  bit          m_wr_err    = 0;

  int          m_back, m_wi, m_ri, m_off, m_sh, m_fi;
  bit          m_busy, m_bad;
  logic [31:0] m_mask;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_front = 0; m_pending = 0; m_fill_left = 0;
      m_rd_data = '0; m_rd_valid = 0; m_rd_known = 1; m_wr_err = 0;
    end else begin
      m_back = 1 - m_front;
      m_busy = (m_fill_left > 0);
      // display read of the front bank
      if (rd_en) begin
        m_ri = int'(rd_addr[AW-1:0]);
        if (m_ri < DEPTH) begin
          m_rd_data  = m_mem[m_front][m_ri];
          m_rd_known = m_known[m_front][m_ri];
        end else begin
          m_rd_data  = '0;
          m_rd_known = 1;
        end
      end
      m_rd_valid = rd_en;
      // CPU write into the back bank
      m_wr_err = 0;
      if (wr_en) begin
        m_wi  = int'(wr_addr[AW+1:2]);
        m_off = int'(wr_addr[1:0]);
        m_bad = (m_wi >= DEPTH) || (wr_size == 2'b11) || m_busy ||
                (wr_size == 2'b01 && (m_off % 2) == 1) ||
                (wr_size == 2'b10 && m_off != 0);
        if (m_bad) begin
          m_wr_err = 1;
        end else begin
          if (wr_size == 2'b00) begin
            m_sh = 8 * (3 - m_off);  m_mask = 32'h0000_00FF << m_sh;
          end else if (wr_size == 2'b01) begin
            m_sh = (m_off >= 2) ? 0 : 16; m_mask = 32'h0000_FFFF << m_sh;
          end else begin
            m_sh = 0; m_mask = 32'hFFFF_FFFF;
          end
          m_mem[m_back][m_wi] = (m_mem[m_back][m_wi] & ~m_mask) | ((wr_data << m_sh) & m_mask);
          if (m_mask == 32'hFFFF_FFFF) m_known[m_back][m_wi] = 1;
        end
      end
      // fill: one word per cycle, ascending
      if (m_busy) begin
        m_fi = DEPTH - m_fill_left;
        m_mem[m_back][m_fi]   = m_fill_val;
        m_known[m_back][m_fi] = 1;
        m_fill_left--;
      end else if (clr_start) begin
        m_fill_left = DEPTH;
        m_fill_val  = clr_value;
      end
      // swap
      if (frame_start && (m_pending || swap_req) && !m_busy) begin
        m_front   = 1 - m_front;
        m_pending = 0;
      end else if (swap_req) begin
        m_pending = 1;
      end
    end
  end

  always @(negedge clk) begin
    check("rd_valid", 32'(rd_valid), 32'(m_rd_valid));
    if (m_rd_known) check("rd_data", rd_data, m_rd_data);
    check("front_sel", 32'(front_sel), 32'(m_front));
    check("swap_pending", 32'(swap_pending), 32'(m_pending));
    check("clr_busy", 32'(clr_busy), 32'(m_fill_left > 0));
    check("wr_err", 32'(wr_err), 32'(m_wr_err));
  end

  // --------------------------------------------------------------------------
  // Stimulus helpers (inputs change 1 time unit after the rising edge)
  // --------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d);
    wr_en = 1'b1; wr_size = sz; wr_addr = a; wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic do_read(input int idx);
    rd_en = 1'b1; rd_addr = 32'(idx);
    tick();
    rd_en = 1'b0;
  endtask

  task automatic do_swap();
    swap_req = 1'b1;
    tick();
    swap_req = 1'b0; frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  task automatic fill_and_wait(input logic [31:0] v);
    int n;
    clr_value = v; clr_start = 1'b1;
    tick();
    clr_start = 1'b0;
    n = 0;
    while (clr_busy && n < 100) begin
      tick();
      n++;
    end
    check("fill_done", 32'(clr_busy), 32'd0);
  endtask

  // --------------------------------------------------------------------------
  // Directed sequence
  // --------------------------------------------------------------------------
  initial begin
    int n;
    // reset state
    repeat (3) tick();
    check("rst_rd_data", rd_data, 32'h0);
    check("rst_rd_valid", 32'(rd_valid), 32'd0);
    check("rst_front_sel", 32'(front_sel), 32'd0);
    check("rst_swap_pending", 32'(swap_pending), 32'd0);
    check("rst_clr_busy", 32'(clr_busy), 32'd0);
    check("rst_wr_err", 32'(wr_err), 32'd0);
    rst_n = 1'b1;
    tick();

    // bring both banks to a known zero state, front back to bank 0
    fill_and_wait(32'h0);
    do_swap();
    fill_and_wait(32'h0);
    do_swap();
    check("init_front", 32'(front_sel), 32'd0);

    // word write, swap, read back
    do_write(2'b10, 32'h10, 32'hDEAD_BEEF);
    do_swap();
    do_read(4);
    check("word_rd", rd_data, 32'hDEAD_BEEF);
    check("word_valid", 32'(rd_valid), 32'd1);
    check("word_front", 32'(front_sel), 32'd1);
    tick();
    check("hold_rd", rd_data, 32'hDEAD_BEEF);
    check("hold_valid", 32'(rd_valid), 32'd0);

    // byte lanes into both banks, then a half-word merge
    for (int i = 0; i < 4; i++) do_write(2'b00, 32'h20 + 32'(i), 32'(8'h11 * (i + 1)));
    do_swap();
    for (int i = 0; i < 4; i++) do_write(2'b00, 32'h20 + 32'(i), 32'(8'h11 * (i + 1)));
    do_read(8);
    check("bytes_rd", rd_data, 32'h1122_3344);
    do_write(2'b01, 32'h22, 32'h0000_ABCD);
    do_swap();
    do_read(8);
    check("half_rd", rd_data, 32'h1122_ABCD);

    // dropped writes
    do_write(2'b10, 32'h02, 32'hFFFF_FFFF);
    check("err_word_misalign", 32'(wr_err), 32'd1);
    do_write(2'b01, 32'h01, 32'hFFFF_FFFF);
    check("err_half_misalign", 32'(wr_err), 32'd1);
    do_write(2'b10, 32'(9600 * 4), 32'hFFFF_FFFF);
    check("err_idx_9600", 32'(wr_err), 32'd1);
    do_write(2'b10, 32'(DEPTH * 4), 32'hFFFF_FFFF);
    check("err_idx_depth", 32'(wr_err), 32'd1);
    do_write(2'b11, 32'h00, 32'hFFFF_FFFF);
    check("err_size_11", 32'(wr_err), 32'd1);
    do_write(2'b00, 32'h03, 32'h0000_0077);
    check("ok_byte_no_err", 32'(wr_err), 32'd0);
    do_swap();
    do_read(0);
    check("dropped_unchanged", rd_data, 32'h0000_0077);
    do_read(DEPTH);
    check("rd_oob_depth", rd_data, 32'h0);
    do_read(9600);
    check("rd_oob_9600", rd_data, 32'h0);

    // fill with a swap held off mid-fill, a restart attempt and a write attempt
    clr_value = 32'hFFFF_0000; clr_start = 1'b1;
    tick();
    clr_start = 1'b0;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      if (!clr_busy) break;
      n++;
      rd_en       = 1'b1;
      rd_addr     = 32'(i % DEPTH);
      swap_req    = (i == 1);
      clr_start   = (i == 3);
      clr_value   = (i == 3) ? 32'h1234_5678 : 32'hFFFF_0000;
      frame_start = (i == 6);
      wr_en       = (i == 12);
      wr_size     = 2'b10;
      wr_addr     = 32'h08;
      wr_data     = 32'h0BAD_0BAD;
      tick();
      if (i == 8) begin
        check("midfill_pending", 32'(swap_pending), 32'd1);
        check("midfill_front", 32'(front_sel), 32'd0);
      end
    end
    rd_en = 1'b0; swap_req = 1'b0; clr_start = 1'b0; frame_start = 1'b0; wr_en = 1'b0;
    check("fill_busy_cycles", 32'(n), 32'd16);
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    check("postfill_front", 32'(front_sel), 32'd1);
    check("postfill_pending", 32'(swap_pending), 32'd0);
    for (int i = 0; i < DEPTH; i++) begin
      rd_en = 1'b1; rd_addr = 32'(i);
      tick();
      check("fill_word", rd_data, 32'hFFFF_0000);
    end
    rd_en = 1'b0;

    // swap_req and frame_start together
    swap_req = 1'b1; frame_start = 1'b1;
    tick();
    swap_req = 1'b0; frame_start = 1'b0;
    check("same_cycle_front", 32'(front_sel), 32'd0);
    check("same_cycle_pending", 32'(swap_pending), 32'd0);

    // reset in the middle of a fill
    clr_value = 32'hA5A5_A5A5; clr_start = 1'b1;
    tick();
    clr_start = 1'b0;
    repeat (5) tick();
    rst_n = 1'b0;
    #1;
    check("abort_busy", 32'(clr_busy), 32'd0);
    check("abort_front", 32'(front_sel), 32'd0);
    check("abort_pending", 32'(swap_pending), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    do_write(2'b10, 32'h0C, 32'hCAFE_F00D);
    check("post_rst_write_ok", 32'(wr_err), 32'd0);
    do_swap();
    do_read(3);
    check("post_rst_word", rd_data, 32'hCAFE_F00D);
    do_read(4);
    check("partial_fill_4", rd_data, 32'hA5A5_A5A5);
    do_read(5);
    check("partial_fill_5", rd_data, 32'hFFFF_0000);

    repeat (3) tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
